coco_ps2_matrix: RTL and testbench

//  Converts MiSTer ps2_key events into the CoCo2 8x7 keyboard switch matrix. Sits between
//  hps_io (ps2_key) and the PIA0 keyboard port inside the po8 system.
//  - PIA drives column strobes (PB7..0, active-low); block returns row sense (PA6..0, active-low).
//  - Holds a 56-bit key-down state updated by a 3-stage event pipeline.

---
 rtl/coco_ps2_matrix_pkg.sv | 42 ++++
 rtl/coco_ps2_matrix_if.sv | 20 ++
 rtl/coco_ps2_matrix_rom.sv | 124 ++++++++++++
 rtl/coco_ps2_matrix.sv | 126 ++++++++++++
 tb/tb_coco_ps2_matrix.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/coco_ps2_matrix_pkg.sv
// Shared types and constants for the PS/2 to CoCo2 keyboard matrix converter.
package coco_ps2_matrix_pkg;

    // Decoded matrix position for one scancode; valid=0 means "not a matrix key".
    typedef struct packed {
        logic       valid;
        logic [2:0] row;
        logic [2:0] col;
    } kbd_pos_t;

    localparam int NUM_ROWS = 7;
    localparam int NUM_COLS = 8;

    // SHIFT lives in the matrix but is driven from the two shift flags.
    localparam logic [2:0] ROW_SHIFT = 3'd6;
    localparam logic [2:0] COL_SHIFT = 3'd7;

    // PS/2 set-2 scancodes that need special handling.
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_HOME   = 8'h6C;
    localparam logic [7:0] SC_LCTRL  = 8'h14;
    localparam logic [7:0] SC_LALT   = 8'h11;
    localparam logic [7:0] SC_F1     = 8'h05;
    localparam logic [7:0] SC_F2     = 8'h06;

    // Build a valid matrix position.
    function automatic kbd_pos_t kpos(input logic [2:0] r, input logic [2:0] c);
        kbd_pos_t p;
        p.valid = 1'b1;
        p.row   = r;
        p.col   = c;
        return p;
    endfunction

endpackage

// File: rtl/coco_ps2_matrix_if.sv
// Keyboard-side bus of the matrix converter: PS/2 events in, PIA0 strobe/sense.
interface coco_ps2_matrix_if;
    logic [10:0] ps2_key;
    logic        kbd_clear;
    logic [7:0]  key_col_n;
    logic [6:0]  key_row_n;
    logic        any_key;

    // Host side: hps_io / PIA0 model.
    modport master (
        output ps2_key, kbd_clear, key_col_n,
        input  key_row_n, any_key
    );

    // Converter side.
    modport slave (
        input  ps2_key, kbd_clear, key_col_n,
        output key_row_n, any_key
    );
endinterface

// File: rtl/coco_ps2_matrix_rom.sv
// Registered scancode lookup: {ext,code} -> matrix position plus shift flags.
module coco_ps2_matrix_rom
    import coco_ps2_matrix_pkg::*;
#(
    parameter int BKSP_IS_LEFT  = 1,
    parameter int KEYPAD_ARROWS = 0
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       vld_i,
    input  logic       make_i,
    input  logic       ext_i,
    input  logic [7:0] code_i,
    output logic       vld_o,
    output logic       make_o,
    output kbd_pos_t   pos_o,
    output logic       is_lshift_o,
    output logic       is_rshift_o
);

    kbd_pos_t pos_d, pos_q;
    logic     lsh_d, rsh_d, lsh_q, rsh_q;
    logic     vld_p1_q, make_p1_q;

    // Table lookup; extended and plain codes live in separate spaces so a
    // prefix mismatch simply finds no entry.
    always_comb begin
        pos_d = '0;
        lsh_d = 1'b0;
        rsh_d = 1'b0;
        if (!ext_i) begin
            case (code_i)
                8'h52:     pos_d = kpos(3'd0, 3'd0); // ' -> @
                8'h1C:     pos_d = kpos(3'd0, 3'd1); // A
                8'h32:     pos_d = kpos(3'd0, 3'd2); // B
                8'h21:     pos_d = kpos(3'd0, 3'd3); // C
                8'h23:     pos_d = kpos(3'd0, 3'd4); // D
                8'h24:     pos_d = kpos(3'd0, 3'd5); // E
                8'h2B:     pos_d = kpos(3'd0, 3'd6); // F
                8'h34:     pos_d = kpos(3'd0, 3'd7); // G
                8'h33:     pos_d = kpos(3'd1, 3'd0); // H
                8'h43:     pos_d = kpos(3'd1, 3'd1); // I
                8'h3B:     pos_d = kpos(3'd1, 3'd2); // J
                8'h42:     pos_d = kpos(3'd1, 3'd3); // K
                8'h4B:     pos_d = kpos(3'd1, 3'd4); // L
                8'h3A:     pos_d = kpos(3'd1, 3'd5); // M
                8'h31:     pos_d = kpos(3'd1, 3'd6); // N
                8'h44:     pos_d = kpos(3'd1, 3'd7); // O
                8'h4D:     pos_d = kpos(3'd2, 3'd0); // P
                8'h15:     pos_d = kpos(3'd2, 3'd1); // Q
                8'h2D:     pos_d = kpos(3'd2, 3'd2); // R
                8'h1B:     pos_d = kpos(3'd2, 3'd3); // S
                8'h2C:     pos_d = kpos(3'd2, 3'd4); // T
                8'h3C:     pos_d = kpos(3'd2, 3'd5); // U
                8'h2A:     pos_d = kpos(3'd2, 3'd6); // V
                8'h1D:     pos_d = kpos(3'd2, 3'd7); // W
                8'h22:     pos_d = kpos(3'd3, 3'd0); // X
                8'h35:     pos_d = kpos(3'd3, 3'd1); // Y
                8'h1A:     pos_d = kpos(3'd3, 3'd2); // Z
                8'h29:     pos_d = kpos(3'd3, 3'd7); // SPACE
                8'h45:     pos_d = kpos(3'd4, 3'd0); // 0
                8'h16:     pos_d = kpos(3'd4, 3'd1); // 1
                8'h1E:     pos_d = kpos(3'd4, 3'd2); // 2
                8'h26:     pos_d = kpos(3'd4, 3'd3); // 3
                8'h25:     pos_d = kpos(3'd4, 3'd4); // 4
                8'h2E:     pos_d = kpos(3'd4, 3'd5); // 5
                8'h36:     pos_d = kpos(3'd4, 3'd6); // 6
                8'h3D:     pos_d = kpos(3'd4, 3'd7); // 7
                8'h3E:     pos_d = kpos(3'd5, 3'd0); // 8
                8'h46:     pos_d = kpos(3'd5, 3'd1); // 9
                8'h55:     pos_d = kpos(3'd5, 3'd2); // = -> :
                8'h4C:     pos_d = kpos(3'd5, 3'd3); // ;
                8'h41:     pos_d = kpos(3'd5, 3'd4); // ,
                8'h4E:     pos_d = kpos(3'd5, 3'd5); // -
                8'h49:     pos_d = kpos(3'd5, 3'd6); // .
                8'h4A:     pos_d = kpos(3'd5, 3'd7); // /
                8'h5A:     pos_d = kpos(3'd6, 3'd0); // ENTER
                SC_ESC:    pos_d = kpos(3'd6, 3'd2); // BREAK
                SC_LALT:   pos_d = kpos(3'd6, 3'd3); // ALT
                SC_LCTRL:  pos_d = kpos(3'd6, 3'd4); // CTRL
                SC_F1:     pos_d = kpos(3'd6, 3'd5); // F1
                SC_F2:     pos_d = kpos(3'd6, 3'd6); // F2
                SC_LSHIFT: lsh_d = 1'b1;
                SC_RSHIFT: rsh_d = 1'b1;
                SC_BKSP:   if (BKSP_IS_LEFT != 0)  pos_d = kpos(3'd3, 3'd5);
                SC_UP:     if (KEYPAD_ARROWS != 0) pos_d = kpos(3'd3, 3'd3);
                SC_DOWN:   if (KEYPAD_ARROWS != 0) pos_d = kpos(3'd3, 3'd4);
                SC_LEFT:   if (KEYPAD_ARROWS != 0) pos_d = kpos(3'd3, 3'd5);
                SC_RIGHT:  if (KEYPAD_ARROWS != 0) pos_d = kpos(3'd3, 3'd6);
                default:   pos_d = '0;
            endcase
        end else begin
            case (code_i)
                SC_UP:    pos_d = kpos(3'd3, 3'd3);
                SC_DOWN:  pos_d = kpos(3'd3, 3'd4);
                SC_LEFT:  pos_d = kpos(3'd3, 3'd5);
                SC_RIGHT: pos_d = kpos(3'd3, 3'd6);
                SC_HOME:  pos_d = kpos(3'd6, 3'd1); // CLEAR
                default:  pos_d = '0;
            endcase
        end
    end

    // Stage valid: the only S1 state that must start clean.
    always_ff @(posedge clk_sys) begin
        if (reset) vld_p1_q <= 1'b0;
        else       vld_p1_q <= vld_i;
    end

    // Stage payload, qualified by vld_p1_q downstream.
    always_ff @(posedge clk_sys) begin
        make_p1_q <= make_i;
        pos_q     <= pos_d;
        lsh_q     <= lsh_d;
        rsh_q     <= rsh_d;
    end

    assign vld_o       = vld_p1_q;
    assign make_o      = make_p1_q;
    assign pos_o       = pos_q;
    assign is_lshift_o = lsh_q;
    assign is_rshift_o = rsh_q;

endmodule

// File: rtl/coco_ps2_matrix.sv
// PS/2 key events -> CoCo2 8x7 keyboard matrix as seen by PIA0.
module coco_ps2_matrix
    import coco_ps2_matrix_pkg::*;
#(
    parameter int BKSP_IS_LEFT  = 1,
    parameter int KEYPAD_ARROWS = 0
) (
    input logic               clk_sys,
    input logic               reset,
    coco_ps2_matrix_if.slave  kbd
);

    logic [10:0] ps2_in_q;
    logic        tog_q;
    logic        evt;
    logic        vld_p0_q, make_p0_q, ext_p0_q;
    logic [7:0]  code_p0_q;

    logic        vld_p1, make_p1, lsh_p1, rsh_p1;
    kbd_pos_t    pos_p1;

    logic [NUM_ROWS-1:0][NUM_COLS-1:0] matrix_d, matrix_q, matrix_eff;
    logic        lsh_d, lsh_q, rsh_d, rsh_q;
    logic [6:0]  key_row_n_d, key_row_n_q;
    logic        any_key_q;

    // Input register isolates the hps_io path from the toggle detector.
    always_ff @(posedge clk_sys) begin
        ps2_in_q <= kbd.ps2_key;
    end

    assign evt = ps2_in_q[10] ^ tog_q;

    // S0: toggle detect; tog_q follows the live input during reset so
    // releasing reset never manufactures an event.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tog_q    <= kbd.ps2_key[10];
            vld_p0_q <= 1'b0;
        end else begin
            tog_q    <= ps2_in_q[10];
            vld_p0_q <= evt;
        end
    end

    // S0 payload capture.
    always_ff @(posedge clk_sys) begin
        if (evt) begin
            make_p0_q <= ps2_in_q[9];
            ext_p0_q  <= ps2_in_q[8];
            code_p0_q <= ps2_in_q[7:0];
        end
    end

    // ---- S1: scancode decode ----
    coco_ps2_matrix_rom #(
        .BKSP_IS_LEFT  (BKSP_IS_LEFT),
        .KEYPAD_ARROWS (KEYPAD_ARROWS)
    ) u_rom (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .vld_i       (vld_p0_q),
        .make_i      (make_p0_q),
        .ext_i       (ext_p0_q),
        .code_i      (code_p0_q),
        .vld_o       (vld_p1),
        .make_o      (make_p1),
        .pos_o       (pos_p1),
        .is_lshift_o (lsh_p1),
        .is_rshift_o (rsh_p1)
    );

    // S2 next state: clear overrides any update landing in the same cycle.
    always_comb begin
        matrix_d = matrix_q;
        lsh_d    = lsh_q;
        rsh_d    = rsh_q;
        if (kbd.kbd_clear) begin
            matrix_d = '0;
            lsh_d    = 1'b0;
            rsh_d    = 1'b0;
        end else if (vld_p1) begin
            if (pos_p1.valid) matrix_d[pos_p1.row][pos_p1.col] = make_p1;
            if (lsh_p1)       lsh_d = make_p1;
            if (rsh_p1)       rsh_d = make_p1;
        end
    end

    // S2: key-down state.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            matrix_q <= '0;
            lsh_q    <= 1'b0;
            rsh_q    <= 1'b0;
        end else begin
            matrix_q <= matrix_d;
            lsh_q    <= lsh_d;
            rsh_q    <= rsh_d;
        end
    end

    // Matrix as the PIA sees it: SHIFT held while either shift key is down.
    always_comb begin
        matrix_eff = matrix_q;
        matrix_eff[ROW_SHIFT][COL_SHIFT] = lsh_q | rsh_q;
        key_row_n_d = '1;
        for (int r = 0; r < NUM_ROWS; r++) begin
            key_row_n_d[r] = ~|(matrix_eff[r] & ~kbd.key_col_n);
        end
    end

    // Registered row sense and activity flag.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            key_row_n_q <= 7'h7F;
            any_key_q   <= 1'b0;
        end else begin
            key_row_n_q <= key_row_n_d;
            any_key_q   <= (|matrix_q) | lsh_q | rsh_q;
        end
    end

    assign kbd.key_row_n = key_row_n_q;
    assign kbd.any_key   = any_key_q;

endmodule

// File: tb/tb_coco_ps2_matrix.sv
// Directed bench for coco_ps2_matrix.
module tb_coco_ps2_matrix;

    logic clk_sys = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    coco_ps2_matrix_if bus();

    coco_ps2_matrix #(.BKSP_IS_LEFT(1), .KEYPAD_ARROWS(0)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .kbd     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // Toggle ps2_key just after an edge; the next edge is edge N of the event.
    task automatic send(input logic mk, input logic ex, input logic [7:0] code);
        @(posedge clk_sys);
        #1 bus.ps2_key = {~bus.ps2_key[10], mk, ex, code};
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        bus.ps2_key   = {1'b1, 1'b1, 1'b0, 8'h1C};
        bus.kbd_clear = 1'b0;
        bus.key_col_n = 8'h00;
        reset = 1'b1;
        wait_cycles(4);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wait_cycles(1);
            tests++;
            if (bus.key_row_n !== 7'h7F || bus.any_key !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle cyc %0d: row_n=%h any=%b expected 7f/0", i, bus.key_row_n, bus.any_key);
            end
        end
    endtask

    task automatic test_make_a();
        bus.key_col_n = 8'hFD;
        send(1'b1, 1'b0, 8'h1C);
        repeat (4) @(posedge clk_sys);
        #1;
        tests++;
        if (bus.key_row_n !== 7'h7F) begin
            fails++;
            $display("FAIL a_early: row_n=%h expected 7f at N+3", bus.key_row_n);
        end
        wait_cycles(1);
        tests++;
        if (bus.key_row_n !== 7'h7E) begin
            fails++;
            $display("FAIL a_latency: row_n=%h expected 7e at N+4", bus.key_row_n);
        end
        tests++;
        if (bus.any_key !== 1'b1) begin
            fails++;
            $display("FAIL a_any: any=%b expected 1", bus.any_key);
        end
        bus.key_col_n = 8'hFE;
        wait_cycles(2);
        tests++;
        if (bus.key_row_n !== 7'h7F) begin
            fails++;
            $display("FAIL a_wrong_col: row_n=%h expected 7f", bus.key_row_n);
        end
        bus.key_col_n = 8'hFD;
        send(1'b0, 1'b0, 8'h1C);
        wait_cycles(6);
        tests++;
        if (bus.key_row_n !== 7'h7F || bus.any_key !== 1'b0) begin
            fails++;
            $display("FAIL a_break: row_n=%h any=%b expected 7f/0", bus.key_row_n, bus.any_key);
        end
    endtask

    task automatic test_shift();
        bus.key_col_n = 8'h7F;
        send(1'b1, 1'b0, 8'h12);
        send(1'b1, 1'b0, 8'h59);
        send(1'b0, 1'b0, 8'h12);
        wait_cycles(6);
        tests++;
        if (bus.key_row_n !== 7'h3F) begin
            fails++;
            $display("FAIL shift_rhold: row_n=%h expected 3f", bus.key_row_n);
        end
        send(1'b0, 1'b0, 8'h59);
        wait_cycles(6);
        tests++;
        if (bus.key_row_n !== 7'h7F || bus.any_key !== 1'b0) begin
            fails++;
            $display("FAIL shift_release: row_n=%h any=%b expected 7f/0", bus.key_row_n, bus.any_key);
        end
    endtask

    task automatic test_arrows();
        bus.key_col_n = 8'hF7;
        send(1'b1, 1'b0, 8'h75);
        wait_cycles(6);
        tests++;
        if (bus.key_row_n !== 7'h7F) begin
            fails++;
            $display("FAIL keypad8_ignored: row_n=%h expected 7f", bus.key_row_n);
        end
        send(1'b1, 1'b1, 8'h75);
        wait_cycles(6);
        tests++;
        if (bus.key_row_n !== 7'h77) begin
            fails++;
            $display("FAIL up_ext: row_n=%h expected 77", bus.key_row_n);
        end
        send(1'b0, 1'b1, 8'h75);
        bus.key_col_n = 8'hDF;
        send(1'b1, 1'b0, 8'h66);
        wait_cycles(6);
        tests++;
        if (bus.key_row_n !== 7'h77) begin
            fails++;
            $display("FAIL bksp_left: row_n=%h expected 77", bus.key_row_n);
        end
        send(1'b0, 1'b0, 8'h66);
        bus.key_col_n = 8'hFD;
        send(1'b1, 1'b1, 8'h1C);
        wait_cycles(6);
        tests++;
        if (bus.key_row_n !== 7'h7F || bus.any_key !== 1'b0) begin
            fails++;
            $display("FAIL ext_mismatch: row_n=%h any=%b expected 7f/0", bus.key_row_n, bus.any_key);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cols [3];
        cols[0] = 8'hFD; cols[1] = 8'hFB; cols[2] = 8'hF7;
        send(1'b1, 1'b0, 8'h1C);
        send(1'b1, 1'b0, 8'h32);
        send(1'b1, 1'b0, 8'h21);
        bus.key_col_n = 8'hF1;
        wait_cycles(6);
        tests++;
        if (bus.key_row_n !== 7'h7E) begin
            fails++;
            $display("FAIL b2b_or: row_n=%h expected 7e", bus.key_row_n);
        end
        for (int i = 0; i < 3; i++) begin
            bus.key_col_n = cols[i];
            wait_cycles(2);
            tests++;
            if (bus.key_row_n !== 7'h7E) begin
                fails++;
                $display("FAIL b2b_key%0d: row_n=%h expected 7e", i, bus.key_row_n);
            end
        end
        send(1'b0, 1'b0, 8'h1C);
        send(1'b0, 1'b0, 8'h32);
        send(1'b0, 1'b0, 8'h21);
        bus.key_col_n = 8'h00;
        wait_cycles(6);
        tests++;
        if (bus.key_row_n !== 7'h7F) begin
            fails++;
            $display("FAIL b2b_break: row_n=%h expected 7f", bus.key_row_n);
        end
    endtask

    task automatic test_clear();
        bus.key_col_n = 8'hFD;
        send(1'b1, 1'b0, 8'h15);
        wait_cycles(6);
        tests++;
        if (bus.key_row_n !== 7'h7B || bus.any_key !== 1'b1) begin
            fails++;
            $display("FAIL q_down: row_n=%h any=%b expected 7b/1", bus.key_row_n, bus.any_key);
        end
        send(1'b1, 1'b0, 8'h1D);
        repeat (3) @(posedge clk_sys);
        #1 bus.kbd_clear = 1'b1;
        @(posedge clk_sys);
        #1 bus.kbd_clear = 1'b0;
        wait_cycles(1);
        tests++;
        if (bus.any_key !== 1'b0) begin
            fails++;
            $display("FAIL clear_any: any=%b expected 0", bus.any_key);
        end
        bus.key_col_n = 8'h00;
        wait_cycles(2);
        tests++;
        if (bus.key_row_n !== 7'h7F) begin
            fails++;
            $display("FAIL clear_wins: row_n=%h expected 7f", bus.key_row_n);
        end
    endtask

    task automatic test_reset_midflight();
        bus.key_col_n = 8'hFD;
        send(1'b1, 1'b0, 8'h1C);
        @(posedge clk_sys);
        #1 reset = 1'b1;
        @(posedge clk_sys);
        #1 reset = 1'b0;
        wait_cycles(6);
        tests++;
        if (bus.key_row_n !== 7'h7F || bus.any_key !== 1'b0) begin
            fails++;
            $display("FAIL reset_flush: row_n=%h any=%b expected 7f/0", bus.key_row_n, bus.any_key);
        end
        send(1'b1, 1'b0, 8'h1C);
        wait_cycles(6);
        tests++;
        if (bus.key_row_n !== 7'h7E) begin
            fails++;
            $display("FAIL post_reset_a: row_n=%h expected 7e", bus.key_row_n);
        end
        send(1'b0, 1'b0, 8'h1C);
        wait_cycles(6);
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_make_a();
        test_shift();
        test_arrows();
        test_back_to_back();
        test_clear();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
